// File: rtl/coeff_update_ctrl.sv
// Coefficient update controller for the transposed FIR filter.
// It streams host coefficients into the four coefficient banks in tap order and zero-pads the unused taps.
module coeff_update_ctrl #(
  parameter int NUM_TAPS   = 40,
  parameter int BANK_DEPTH = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic        iClk_12M,
  input  logic        iRsn,
  input  logic        iEnSample_300k,
  input  logic        iLoadStart,
  input  logic [5:0]  iNumOfCoeff,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeff,
  output logic        oCoeffReady,
  output logic        oCoeffiUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [3:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  localparam int TMOW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_LOAD, S_WRITE, S_GAP, S_PAD_WR, S_PAD_GAP, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  tap_q, tap_d, cnt_q, cnt_d, tap_inc;
  logic [3:0]  bidx_q, bidx_d, bidx_inc;
  logic [TMOW-1:0] tmo_q, tmo_d;
  logic        tmo_err_q, tmo_err_d;
  logic        ready_q, ready_d, flag_q, flag_d, csn_q, csn_d, wrn_q, wrn_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] wrdt_q, wrdt_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    tmo_d     = tmo_q;
    tmo_err_d = tmo_err_q;
    flag_d    = flag_q;
    addr_d    = addr_q;
    wrdt_d    = wrdt_q;
    ready_d   = 1'b0;
    csn_d     = 1'b1;
    wrn_d     = 1'b1;
    done_d    = 1'b0;
    err_d     = 1'b0;
    tap_inc   = tap_q + 6'd1;
    bidx_inc  = (bidx_q == 4'(BANK_DEPTH - 1)) ? 4'd0 : bidx_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        tap_d     = 6'd0;
        bidx_d    = 4'd0;
        tmo_d     = '0;
        tmo_err_d = 1'b0;
        if (iLoadStart) begin
          cnt_d = iNumOfCoeff;
          if ((iNumOfCoeff == 6'd0) || (iNumOfCoeff > 6'(NUM_TAPS))) begin
            err_d = 1'b1;
          end else begin
            state_d = S_SYNC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SYNC: begin
        if (iEnSample_300k) begin
          state_d = S_LOAD;
          flag_d  = 1'b1;
          ready_d = 1'b1;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_LOAD: begin
        if (iCoeffValid) begin
          state_d = S_WRITE;
          csn_d   = 1'b0;
          wrn_d   = 1'b0;
          addr_d  = bidx_q;
          wrdt_d  = iCoeff;
          tmo_d   = '0;
        end else if (tmo_q == TMOW'(TIMEOUT - 1)) begin
          // Host gave up: fill the remaining taps with zeros so every bank stays defined.
          state_d   = S_PAD_WR;
          tmo_err_d = 1'b1;
          csn_d     = 1'b0;
          wrn_d     = 1'b0;
          addr_d    = bidx_q;
          wrdt_d    = 16'h0000;
        end else begin
          tmo_d   = tmo_q + TMOW'(1);
          ready_d = 1'b1;
        end
      end
      S_WRITE:    state_d = S_GAP;
      S_PAD_WR:   state_d = S_PAD_GAP;
      S_GAP, S_PAD_GAP: begin
        tap_d  = tap_inc;
        bidx_d = bidx_inc;
        if (tap_inc == 6'(NUM_TAPS)) begin
          state_d = S_FIN;
        end else if ((state_q == S_GAP) && (tap_inc != cnt_q)) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
        end else begin
          state_d = S_PAD_WR;
          csn_d   = 1'b0;
          wrn_d   = 1'b0;
          addr_d  = bidx_inc;
          wrdt_d  = 16'h0000;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        flag_d  = 1'b0;
        done_d  = ~tmo_err_q;
        err_d   = tmo_err_q;
      end
      default: begin
        state_d = S_IDLE;
        flag_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q   <= S_IDLE;
      tap_q     <= 6'd0;
      cnt_q     <= 6'd0;
      bidx_q    <= 4'd0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
      ready_q   <= 1'b0;
      flag_q    <= 1'b0;
      csn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      addr_q    <= 4'd0;
      wrdt_q    <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      cnt_q     <= cnt_d;
      bidx_q    <= bidx_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
      ready_q   <= ready_d;
      flag_q    <= flag_d;
      csn_q     <= csn_d;
      wrn_q     <= wrn_d;
      addr_q    <= addr_d;
      wrdt_q    <= wrdt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign oCoeffReady       = ready_q;
  assign oCoeffiUpdateFlag = flag_q;
  assign oCsnRam           = csn_q;
  assign oWrnRam           = wrn_q;
  assign oAddrRam          = addr_q;
  assign oWrDtRam          = wrdt_q;
  assign oBusy             = busy_q;
  assign oDone             = done_q;
  assign oErr              = err_q;

endmodule

// File: tb/tb_coeff_update_ctrl.sv
// Directed bench for coeff_update_ctrl: full, short, illegal, stalled, aligned and reset-interrupted loads.
module tb_coeff_update_ctrl;

  logic        clk = 1'b0;
  logic        iRsn, iEnSample_300k, iLoadStart, iCoeffValid;
  logic [5:0]  iNumOfCoeff;
  logic [15:0] iCoeff;
  logic        oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oBusy, oDone, oErr;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;

  int checks = 0;
  int errors = 0;

  logic [3:0]  wa [0:63];
  logic [15:0] wd [0:63];
  logic [15:0] hd [0:39];
  int n_wr, flag_cycles, done_cnt, err_cnt, ready_late, strobe_bad, rise_bad;
  int host_n, host_idx, host_limit, samp_cnt;
  logic host_on, prev_ready, prev_flag, prev_strobe;

  coeff_update_ctrl dut (
    .iClk_12M(clk), .iRsn(iRsn), .iEnSample_300k(iEnSample_300k),
    .iLoadStart(iLoadStart), .iNumOfCoeff(iNumOfCoeff), .iCoeffValid(iCoeffValid),
    .iCoeff(iCoeff), .oCoeffReady(oCoeffReady), .oCoeffiUpdateFlag(oCoeffiUpdateFlag),
    .oCsnRam(oCsnRam), .oWrnRam(oWrnRam), .oAddrRam(oAddrRam), .oWrDtRam(oWrDtRam),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance host and sample-strobe stimulus, then record what the DUT shows this cycle.
  task automatic step();
    @(posedge clk);
    #1;
    if (prev_ready && iCoeffValid) host_idx++;
    iCoeffValid = host_on && (host_idx < host_n);
    iCoeff      = (host_idx < 40) ? hd[host_idx] : 16'h0000;
    samp_cnt    = (samp_cnt == 39) ? 0 : samp_cnt + 1;
    prev_strobe = iEnSample_300k;
    iEnSample_300k = (samp_cnt == 0);
    iLoadStart  = 1'b0;
    if (!oCsnRam && !oWrnRam) begin
      if (n_wr < 64) begin
        wa[n_wr] = oAddrRam;
        wd[n_wr] = oWrDtRam;
      end
      n_wr++;
      if (!oCoeffiUpdateFlag) strobe_bad++;
    end
    if (oCoeffiUpdateFlag) begin
      flag_cycles++;
      if (!prev_flag && !prev_strobe) rise_bad++;
    end
    prev_flag = oCoeffiUpdateFlag;
    if (oDone) done_cnt++;
    if (oErr) err_cnt++;
    if (oCoeffReady && (n_wr >= host_limit)) ready_late++;
    prev_ready = oCoeffReady;
  endtask

  task automatic clear_mon();
    n_wr = 0; flag_cycles = 0; done_cnt = 0; err_cnt = 0;
    ready_late = 0; strobe_bad = 0; rise_bad = 0;
    host_idx = 0; host_n = 0; host_on = 1'b0; host_limit = 40;
    prev_ready = 1'b0; iCoeffValid = 1'b0;
  endtask

  task automatic start_load(input logic [5:0] n);
    iNumOfCoeff = n;
    iLoadStart  = 1'b1;
    step();
  endtask

  task automatic run_to_end(input int budget);
    int d0;
    int k;
    d0 = done_cnt + err_cnt;
    k  = 0;
    while ((done_cnt + err_cnt == d0) && (k < budget)) begin
      step();
      k++;
    end
    chk("end_within_budget", (k < budget), 1);
    repeat (3) step();
  endtask

  task automatic check_strobes(input string tag, input int n_host);
    chk({tag, "_strobes"}, n_wr, 40);
    for (int i = 0; i < 40; i++) begin
      chk({tag, "_addr"}, wa[i], i % 10);
      chk({tag, "_data"}, wd[i], (i < n_host) ? hd[i] : 16'h0000);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_csn"}, oCsnRam, 1'b1);
    chk({tag, "_wrn"}, oWrnRam, 1'b1);
    chk({tag, "_addr"}, oAddrRam, 4'd0);
    chk({tag, "_wrdt"}, oWrDtRam, 16'h0000);
    chk({tag, "_flag"}, oCoeffiUpdateFlag, 1'b0);
    chk({tag, "_ready"}, oCoeffReady, 1'b0);
    chk({tag, "_busy"}, oBusy, 1'b0);
    chk({tag, "_done"}, oDone, 1'b0);
    chk({tag, "_err"}, oErr, 1'b0);
  endtask

  initial begin
    int k;
    iRsn = 1'b0; iEnSample_300k = 1'b0; iLoadStart = 1'b0;
    iNumOfCoeff = 6'd0; iCoeff = 16'h0000; samp_cnt = 0;
    prev_flag = 1'b0; prev_strobe = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    iRsn = 1'b1;
    repeat (3) step();

    // Full 40-tap load, valid held high.
    clear_mon();
    for (int i = 0; i < 40; i++) hd[i] = 16'(i + 1);
    host_n = 40; host_on = 1'b1;
    start_load(6'd40);
    chk("full_busy", oBusy, 1'b1);
    run_to_end(400);
    check_strobes("full", 40);
    chk("full_flag_cycles", flag_cycles, 121);
    chk("full_done", done_cnt, 1);
    chk("full_err", err_cnt, 0);
    chk("full_host_taken", host_idx, 40);
    chk("full_strobe_no_flag", strobe_bad, 0);
    chk("full_flag_rise", rise_bad, 0);
    chk("full_ready_late", ready_late, 0);
    chk("full_idle_busy", oBusy, 1'b0);

    // 13 host coefficients, 27 zero pads.
    clear_mon();
    hd[0] = 16'h7FFF; hd[1] = 16'h8000;
    for (int i = 2; i < 40; i++) hd[i] = 16'(16'h0100 + i);
    host_n = 40; host_on = 1'b1; host_limit = 13;
    start_load(6'd13);
    run_to_end(400);
    check_strobes("short", 13);
    chk("short_host_taken", host_idx, 13);
    chk("short_flag_cycles", flag_cycles, 94);
    chk("short_ready_in_pad", ready_late, 0);
    chk("short_done", done_cnt, 1);
    chk("short_err", err_cnt, 0);

    // Illegal counts 0 and 41.
    clear_mon();
    start_load(6'd0);
    chk("cnt0_err_pulse", oErr, 1'b1);
    chk("cnt0_busy", oBusy, 1'b0);
    step();
    chk("cnt0_err_one_cycle", oErr, 1'b0);
    start_load(6'd41);
    chk("cnt41_err_pulse", oErr, 1'b1);
    repeat (60) step();
    chk("illegal_err_cnt", err_cnt, 2);
    chk("illegal_done_cnt", done_cnt, 0);
    chk("illegal_flag", flag_cycles, 0);
    chk("illegal_strobes", n_wr, 0);

    // Host stalls after tap 5: timeout, pad taps 6..39.
    clear_mon();
    for (int i = 0; i < 40; i++) hd[i] = 16'(i + 1);
    host_n = 6; host_on = 1'b1; host_limit = 7;
    start_load(6'd40);
    run_to_end(700);
    check_strobes("stall", 6);
    chk("stall_flag_cycles", flag_cycles, 342);
    chk("stall_err", err_cnt, 1);
    chk("stall_done", done_cnt, 0);
    chk("stall_ready_in_pad", ready_late, 0);

    // Start request 7 cycles after a sample strobe.
    clear_mon();
    hd[0] = 16'h1234;
    host_n = 1; host_on = 1'b1; host_limit = 1;
    k = 0;
    while (!iEnSample_300k && (k < 60)) begin
      step();
      k++;
    end
    chk("align_found_strobe", iEnSample_300k, 1'b1);
    repeat (7) step();
    iNumOfCoeff = 6'd1;
    iLoadStart  = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!oCoeffiUpdateFlag && (k < 100));
    chk("align_flag_delay", k, 34);
    chk("align_no_early_strobe", n_wr, 0);
    run_to_end(300);
    check_strobes("align", 1);
    chk("align_flag_rise", rise_bad, 0);
    chk("align_strobe_no_flag", strobe_bad, 0);
    chk("align_done", done_cnt, 1);

    // Reset asserted during the tap-17 write.
    clear_mon();
    for (int i = 0; i < 40; i++) hd[i] = 16'(i + 1);
    host_n = 40; host_on = 1'b1;
    start_load(6'd40);
    k = 0;
    while ((n_wr < 18) && (k < 300)) begin
      step();
      k++;
    end
    chk("rst_reached_tap17", n_wr, 18);
    chk("rst_tap17_addr", oAddrRam, 4'd7);
    chk("rst_tap17_csn", oCsnRam, 1'b0);
    #2;
    iRsn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    host_on = 1'b0;
    repeat (2) step();
    @(negedge clk);
    iRsn = 1'b1;
    clear_mon();
    hd[0] = 16'hA000; hd[1] = 16'hA001; hd[2] = 16'hA002;
    host_n = 3; host_on = 1'b1; host_limit = 3;
    step();
    start_load(6'd3);
    run_to_end(300);
    check_strobes("after_rst", 3);
    chk("after_rst_done", done_cnt, 1);
    chk("after_rst_err", err_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_update_ctrl.md
Name: coeff_update_ctrl

Overview:
Upstream stage of the reconfigurable transposed FIR filter. It accepts a burst of 16-bit coefficients from the host over a valid/ready stream and drives the filter's coefficient-update port: the update flag, chip-select, write-enable, address and write data. It aligns each update to a sample boundary, writes one coefficient per strobe in tap order, and zero-pads unused taps. This guarantees that all four 10-entry coefficient banks hold defined values after every update.

Parameters:
NUM_TAPS, 40, total coefficient slots (4 banks x BANK_DEPTH)
BANK_DEPTH, 10, entries per bank; the address wraps modulo this value
TIMEOUT, 255, idle cycles allowed while waiting for iCoeffValid before the load is aborted

Ports:
iClk_12M  in  1  12 MHz system clock
iRsn  in  1  asynchronous active-low reset
iEnSample_300k  in  1  one-cycle sample strobe (one per 40 clocks)
iLoadStart  in  1  one-cycle request to begin an update
iNumOfCoeff  in  6  number of host coefficients to expect, legal range 1..40
iCoeffValid  in  1  host coefficient valid
iCoeff  in  16  signed host coefficient
oCoeffReady  out  1  block can accept iCoeff this cycle
oCoeffiUpdateFlag  out  1  filter update window; filtering is frozen while high
oCsnRam  out  1  active-low chip select to filter
oWrnRam  out  1  active-low write enable to filter
oAddrRam  out  4  address within the current bank (tap index mod BANK_DEPTH)
oWrDtRam  out  16  coefficient write data
oBusy  out  1  high in any state other than IDLE
oDone  out  1  one-cycle pulse when the update completes
oErr  out  1  one-cycle pulse on an illegal count or a timeout

Behaviour:
- Reset (async, iRsn=0): state=IDLE. All outputs forced to these values: oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoeffiUpdateFlag=0, oCoeffReady=0, oBusy=0, oDone=0, oErr=0. Tap counter and timeout counter are cleared. Reset mid-update abandons the update immediately; the flag drops in the same instant.
- Bank routing: the filter controller assigns the bank from write order (taps 0-9 to bank 1, 10-19 to bank 2, and so on). This block therefore emits exactly NUM_TAPS strobes per update, in ascending tap order.
- States:
  - IDLE: on iLoadStart, latch iNumOfCoeff.
    - If the value is 0 or greater than 40: pulse oErr next cycle and stay in IDLE.
    - Otherwise go to SYNC.
    - iLoadStart is ignored in every other state.
  - SYNC: wait for iEnSample_300k. On the cycle after the strobe, assert oCoeffiUpdateFlag and go to LOAD.
  - LOAD: oCoeffReady=1. When iCoeffValid=1, capture iCoeff and go to WRITE. Each LOAD cycle without valid increments the timeout counter; on reaching TIMEOUT, set the error flag and go to PAD.
  - WRITE: drive oCsnRam=0, oWrnRam=0, oAddrRam=tap mod BANK_DEPTH, oWrDtRam=captured word for exactly one cycle, then go to GAP.
  - GAP: CSn/WRn=1 for one cycle, tap increments.
    - If tap equals the latched count and tap is less than NUM_TAPS: go to PAD.
    - If tap equals NUM_TAPS: go to FIN.
    - Otherwise: go to LOAD.
  - PAD: WRITE/GAP cycles with data=0, oCoeffReady=0, continuing until tap equals NUM_TAPS, then go to FIN.
  - FIN: deassert oCoeffiUpdateFlag. Next cycle, pulse oDone, or oErr if the timeout flag is set (never both), and return to IDLE.
- Throughput: 3 clocks per coefficient (LOAD accept, WRITE, GAP) when valid is held high. A full 40-tap load takes 120 clocks of flag-high time plus 1 setup cycle.
- oAddrRam sequence is 0..9,0..9,0..9,0..9. The address wraps to 0 after BANK_DEPTH-1, and the tap counter alone determines completion.
- oCoeffReady is never high outside LOAD. Data presented without ready is not consumed.
- Write strobes are issued only while the flag is high. The flag rises no earlier than the cycle after a sample strobe.

Test Plan:
- Full load: iNumOfCoeff=40 with coefficients 1..40 and valid held high -> 40 strobes; addresses repeat 0..9 four times; data 1..40; flag high for 121 cycles; oDone pulse; oErr=0.
- Short load with padding: iNumOfCoeff=13 with data 0x7FFF,0x8000,... -> 13 host writes, then 27 zero writes at addresses 3..9,0..9,0..9; total of 40 strobes; oCoeffReady low during PAD.
- Illegal count: iNumOfCoeff=0, then 41 -> one oErr pulse each; flag never rises; no strobes.
- Host stall: iNumOfCoeff=40, valid drops after tap 5 for 255 cycles -> timeout; taps 6..39 written with 0; oErr pulses; oDone does not pulse.
- Sample alignment: iLoadStart issued 7 cycles after iEnSample_300k -> flag rises exactly 1 cycle after the next strobe (33 cycles later); no strobe occurs before the flag.
- Reset mid-update: assert iRsn=0 during tap 17 WRITE -> all outputs return to reset values asynchronously; a new iLoadStart after reset restarts from address 0.
